// File: rtl/cdc_2phase_pkg.sv
// Shared definitions for the 2-phase CDC transmitter.
//   state_e         : handshake FSM state encoding
//   MIN_SYNC_STAGES : smallest synchroniser depth that is accepted
package cdc_2phase_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_2phase_tx_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, loads RST_VAL into every stage
//   d_i    : asynchronous input bit
//   q_o    : synchronised output (last stage)
module cdc_2phase_tx_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous bit through the synchroniser chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_2phase_tx.sv
// Transmit side of a 2-phase (toggle) clock-domain-crossing handshake.
// A stream word is captured into a register and announced by toggling the
// request line; the word is held until the far side toggles the acknowledge
// to the same level.
// Ports:
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   clr_i        : synchronous clear (counter clear / abort new transfers)
//   src_data_i   : stream payload
//   src_valid_i  : stream valid
//   src_ready_o  : stream ready (word accepted when valid && ready)
//   async_req_o  : 2-phase request, one toggle per word
//   async_data_o : registered payload, stable while a request is outstanding
//   async_ack_i  : 2-phase acknowledge from the far clock domain
//   busy_o       : a request is outstanding
//   xfer_cnt_o   : number of completed transfers (wraps)
module cdc_2phase_tx
  import cdc_2phase_pkg::*;
#(
  parameter type         T           = logic,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  T                     src_data_i,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  output logic                 async_req_o,
  output T                     async_data_o,
  input  logic                 async_ack_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] xfer_cnt_o
);

  // A one-stage synchroniser is not metastability-safe, so clamp the depth.
  localparam int unsigned SYNC_DEPTH =
    (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  state_e               r_state;
  state_e               w_state_next;
  logic                 r_req;
  T                     r_data;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_ack_sync;
  logic                 w_ack_match;
  logic                 w_load;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;

  cdc_2phase_tx_sync #(
    .STAGES  (SYNC_DEPTH),
    .RST_VAL (1'b0)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (async_ack_i),
    .q_o    (w_ack_sync)
  );

  // The far side has consumed the word once its ack level equals our req level.
  assign w_ack_match = (w_ack_sync == r_req);

  // Next-state, load and counter-control decode.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        // Acks seen here belong to nothing outstanding and are ignored.
        if (clr_i) begin
          w_cnt_clr = 1'b1;
        end else if (src_valid_i) begin
          w_load       = 1'b1;
          w_state_next = WAIT;
        end else begin
          w_state_next = IDLE;
        end
      end
      WAIT: begin
        // The toggle is already on the wire, so a clear must wait for its ack.
        if (clr_i) begin
          w_state_next = DRAIN;
        end else if (w_ack_match) begin
          w_state_next = IDLE;
          w_cnt_inc    = 1'b1;
        end else begin
          w_state_next = WAIT;
        end
      end
      DRAIN: begin
        if (w_ack_match) begin
          w_state_next = IDLE;
          w_cnt_clr    = 1'b1;
        end else begin
          w_state_next = DRAIN;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Counter next value; a clear wins over an increment on the same edge.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_cnt_clr) begin
      w_cnt_next = '0;
    end else if (w_cnt_inc) begin
      w_cnt_next = r_cnt + CNT_WIDTH'(1);
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request toggle and payload capture, only on acceptance in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req  <= 1'b0;
      r_data <= '0;
    end else if (w_load) begin
      r_req  <= ~r_req;
      r_data <= src_data_i;
    end else begin
      r_req  <= r_req;
      r_data <= r_data;
    end
  end

  // Completed-transfer counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign src_ready_o  = (r_state == IDLE) && !clr_i;
  assign async_req_o  = r_req;
  assign async_data_o = r_data;
  assign busy_o       = (r_state != IDLE);
  assign xfer_cnt_o   = r_cnt;

endmodule

// File: tb/tb_cdc_2phase_tx.sv
// Directed bench for cdc_2phase_tx. Two instances share all stimulus: one
// with the default 16-bit counter and one with a 2-bit counter for wrap checks.
module tb_cdc_2phase_tx;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic       req;
  logic [7:0] adata;
  logic       ack;
  logic       ack_man;
  logic       ack_loop;
  logic       loop_en;
  logic       busy;
  logic [15:0] cnt;
  logic       src_ready2;
  logic       req2;
  logic [7:0] adata2;
  logic       busy2;
  logic [1:0] cnt2;

  int checks;
  int errors;

  cdc_2phase_tx #(
    .T           (logic [7:0]),
    .SYNC_STAGES (2),
    .CNT_WIDTH   (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .src_data_i   (src_data),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .async_req_o  (req),
    .async_data_o (adata),
    .async_ack_i  (ack),
    .busy_o       (busy),
    .xfer_cnt_o   (cnt)
  );

  cdc_2phase_tx #(
    .T           (logic [7:0]),
    .SYNC_STAGES (2),
    .CNT_WIDTH   (2)
  ) dut_w (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .src_data_i   (src_data),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready2),
    .async_req_o  (req2),
    .async_data_o (adata2),
    .async_ack_i  (ack),
    .busy_o       (busy2),
    .xfer_cnt_o   (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Far side model: immediate loopback of req into ack, one cycle late.
  always @(posedge clk) ack_loop <= req;
  assign ack = loop_en ? ack_loop : ack_man;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    src_data  = w;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; src_valid = 1'b0; src_data = 8'h00;
    ack_man = 1'b0; loop_en = 1'b0;
    #2;
    repeat (3) tick();
    checks++;
    if (src_ready !== 1'b1 || req !== 1'b0 || adata !== 8'h00 || busy !== 1'b0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: ready=%b req=%b data=%h busy=%b cnt=%0d exp 1 0 00 0 0",
               src_ready, req, adata, busy, cnt);
    end
    checks++;
    if (cnt2 !== 2'd0 || req2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w: cnt2=%0d req2=%b exp 0 0", cnt2, req2);
    end
  endtask

  task automatic test_first_word;
    src_valid = 1'b1;
    src_data  = 8'hA5;
    #2 rst_n = 1'b1;
    checks++;
    if (src_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_ready: got %b exp 1", src_ready);
    end
    tick();
    src_valid = 1'b0;
    checks++;
    if (req !== 1'b1 || adata !== 8'hA5 || busy !== 1'b1 || src_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_word: req=%b data=%h busy=%b ready=%b exp 1 a5 1 0",
               req, adata, busy, src_ready);
    end
    // New valid data while waiting must not disturb the held word.
    src_valid = 1'b1;
    src_data  = 8'h5A;
    repeat (3) tick();
    src_valid = 1'b0;
    checks++;
    if (req !== 1'b1 || adata !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_hold: req=%b data=%h busy=%b exp 1 a5 1", req, adata, busy);
    end
  endtask

  task automatic test_ack;
    repeat (5) tick();
    ack_man = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ack_early: busy=%b exp 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || src_ready !== 1'b1 || cnt !== 16'd1 || cnt2 !== 2'd1) begin
      errors++;
      $display("FAIL ack_done: busy=%b ready=%b cnt=%0d cnt2=%0d exp 0 1 1 1",
               busy, src_ready, cnt, cnt2);
    end
  endtask

  task automatic test_spurious;
    ack_man = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || req !== 1'b1 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL spurious_ack: busy=%b req=%b cnt=%0d exp 0 1 1", busy, req, cnt);
    end
    ack_man = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_clear_idle;
    clr       = 1'b1;
    src_valid = 1'b1;
    src_data  = 8'h11;
    #1;
    checks++;
    if (src_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready: got %b exp 0", src_ready);
    end
    tick();
    clr       = 1'b0;
    src_valid = 1'b0;
    checks++;
    if (cnt !== 16'd0 || cnt2 !== 2'd0 || busy !== 1'b0 || req !== 1'b1 || adata !== 8'hA5) begin
      errors++;
      $display("FAIL clr_idle: cnt=%0d cnt2=%0d busy=%b req=%b data=%h exp 0 0 0 1 a5",
               cnt, cnt2, busy, req, adata);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3];
    int   toggles;
    bit   stable_ok;
    bit   done_ok;
    logic prev_req;
    words = '{8'd1, 8'd2, 8'd3};
    toggles = 0;
    loop_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      prev_req = req;
      send_word(words[k]);
      if (req !== prev_req) toggles++;
      stable_ok = 1'b1;
      done_ok   = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (adata !== words[k] || req === prev_req) stable_ok = 1'b0;
        tick();
        if (!busy) begin
          done_ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!stable_ok || !done_ok) begin
        errors++;
        $display("FAIL b2b_word%0d: stable=%b done=%b data=%h exp 1 1 %h",
                 k, stable_ok, done_ok, adata, words[k]);
      end
    end
    checks++;
    if (toggles != 3 || cnt !== 16'd3 || cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL b2b_total: toggles=%0d cnt=%0d cnt2=%0d exp 3 3 3", toggles, cnt, cnt2);
    end
    ack_man = req;
    loop_en = 1'b0;
  endtask

  task automatic test_clear_drain;
    bit ready_ok;
    bit ok;
    send_word(8'h3C);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ready_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (src_ready !== 1'b0 || busy !== 1'b1) ready_ok = 1'b0;
      tick();
    end
    checks++;
    if (!ready_ok || req !== 1'b1) begin
      errors++;
      $display("FAIL drain_hold: ready_ok=%b req=%b exp 1 1", ready_ok, req);
    end
    ack_man = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok || cnt !== 16'd0 || cnt2 !== 2'd0 || req !== 1'b1 || adata !== 8'h3C || src_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_done: ok=%b cnt=%0d cnt2=%0d req=%b data=%h ready=%b exp 1 0 0 1 3c 1",
               ok, cnt, cnt2, req, adata, src_ready);
    end
  endtask

  task automatic test_wrap;
    logic [1:0] exp_w [5];
    bit ok;
    exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    loop_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_word(8'h40 + 8'(k));
      wait_idle(ok);
      checks++;
      if (!ok || cnt2 !== exp_w[k] || cnt !== 16'(k + 1)) begin
        errors++;
        $display("FAIL wrap%0d: ok=%b cnt2=%0d cnt=%0d exp 1 %0d %0d",
                 k, ok, cnt2, cnt, exp_w[k], k + 1);
      end
    end
    ack_man = req;
    loop_en = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    send_word(8'h77);
    checks++;
    if (busy !== 1'b1 || req !== 1'b1 || adata !== 8'h77) begin
      errors++;
      $display("FAIL rst_pre: busy=%b req=%b data=%h exp 1 1 77", busy, req, adata);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || adata !== 8'h00 || busy !== 1'b0 || src_ready !== 1'b1 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid: req=%b data=%h busy=%b ready=%b cnt=%0d exp 0 00 0 1 0",
               req, adata, busy, src_ready, cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    ack_man = 1'b1;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || req !== 1'b0 || src_ready !== 1'b1 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL late_ack: busy=%b req=%b ready=%b cnt=%0d exp 0 0 1 0",
               busy, req, src_ready, cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_word();
    test_ack();
    test_spurious();
    test_clear_idle();
    test_back_to_back();
    test_clear_drain();
    test_wrap();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, exp finish before 200000");
    $fatal(1);
  end

endmodule
